lsu_hs: RTL and testbench



---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu_hs.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_hs.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 memop
// encodings, mcause codes and the fault-cause helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B   = 3'b000;
    localparam logic [2:0] F3_H   = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BU  = 3'b100;
    localparam logic [2:0] F3_HU  = 3'b101;
    localparam logic [2:0] F3_WU  = 3'b110;
    localparam logic [2:0] F3_BAD = 3'b111;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Byte-enable pattern for an access size taken from funct3[1:0].
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] fault_cause(input logic we, input logic misaligned);
        if (misaligned) return we ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
        return we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store strobe/data shifting and load extraction
// with sign/zero extension. The misalignment check exists only with LSU_MISALIGN_TRAP_EN.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int NB = XLEN / 8,
    localparam int OFFW = $clog2(NB)
) (
    input  logic [2:0]      req_memop,
    input  logic [OFFW-1:0] req_off,
    input  logic [XLEN-1:0] req_wdata,
    output logic [NB-1:0]   req_wstrb,
    output logic [XLEN-1:0] req_wdata_sh,
    output logic            req_misalign,
    input  logic [2:0]      rsp_memop,
    input  logic [OFFW-1:0] rsp_off,
    input  logic [XLEN-1:0] rsp_rdata,
    output logic [XLEN-1:0] rsp_ldata
);

    logic [XLEN-1:0] rd_sh;
    logic [63:0]     rd_64;
    logic [63:0]     ld_ext;

    // Lanes shifted past the top of the word fall off; nothing wraps around.
    always_comb begin
        req_wstrb    = NB'(size_mask(req_memop[1:0])) << req_off;
        req_wdata_sh = req_wdata << {req_off, 3'b000};
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] off3;

    always_comb begin
        off3 = 3'(req_off);
        case (req_memop[1:0])
            2'd1:    req_misalign = off3[0];
            2'd2:    req_misalign = |off3[1:0];
            2'd3:    req_misalign = |off3;
            default: req_misalign = 1'b0;
        endcase
    end
`else
    assign req_misalign = 1'b0;
`endif

    // Extension is done at 64 bits so one code path serves both widths.
    always_comb begin
        rd_sh = rsp_rdata >> {rsp_off, 3'b000};
        rd_64 = 64'(rd_sh);
        case (rsp_memop)
            F3_B:    ld_ext = {{56{rd_64[7]}}, rd_64[7:0]};
            F3_H:    ld_ext = {{48{rd_64[15]}}, rd_64[15:0]};
            F3_W:    ld_ext = {{32{rd_64[31]}}, rd_64[31:0]};
            F3_BU:   ld_ext = {56'd0, rd_64[7:0]};
            F3_HU:   ld_ext = {48'd0, rd_64[15:0]};
            F3_WU:   ld_ext = {32'd0, rd_64[31:0]};
            default: ld_ext = rd_64;
        endcase
        rsp_ldata = ld_ext[XLEN-1:0];
    end

endmodule

// File: rtl/lsu_hs.sv
// Load/store unit with a valid/ready memory bus, precise fault reporting and a
// response timeout. Misaligned accesses trap only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_hs
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN-1:0]   req_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_exc,
    output logic [3:0]        rsp_cause,
    output logic [XLEN-1:0]   rsp_pc,
    output logic              busy
);

    localparam int NB    = XLEN / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    lsu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0]      memop_q, memop_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_ready_q, req_ready_d;
    logic            mem_req_valid_q, mem_req_valid_d;
    logic [XLEN-1:0] mem_req_addr_q, mem_req_addr_d;
    logic            mem_req_we_q, mem_req_we_d;
    logic [XLEN-1:0] mem_req_wdata_q, mem_req_wdata_d;
    logic [NB-1:0]   mem_req_wstrb_q, mem_req_wstrb_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_exc_q, rsp_exc_d;
    logic [3:0]      rsp_cause_q, rsp_cause_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;

    logic            illegal;
    logic            misalign;
    logic [NB-1:0]   wstrb_sh;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] ldata;

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_memop    (req_memop),
        .req_off      (req_addr[OFFW-1:0]),
        .req_wdata    (req_wdata),
        .req_wstrb    (wstrb_sh),
        .req_wdata_sh (wdata_sh),
        .req_misalign (misalign),
        .rsp_memop    (memop_q),
        .rsp_off      (off_q),
        .rsp_rdata    (mem_rsp_rdata),
        .rsp_ldata    (ldata)
    );

    // 64-bit-only encodings are illegal on a 32-bit core.
    always_comb begin
        illegal = (req_memop == F3_BAD) ||
                  ((XLEN == 32) && ((req_memop == F3_D) || (!req_we && (req_memop == F3_WU))));
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cnt_inc         = cnt_q + CNT_W'(1);
        memop_d         = memop_q;
        off_d           = off_q;
        pc_d            = pc_q;
        req_ready_d     = req_ready_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_we_d    = mem_req_we_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_wstrb_d = mem_req_wstrb_q;
        rsp_valid_d     = 1'b0;
        rsp_data_d      = rsp_data_q;
        rsp_exc_d       = rsp_exc_q;
        rsp_cause_d     = rsp_cause_q;
        rsp_pc_d        = rsp_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    memop_d     = req_memop;
                    off_d       = req_addr[OFFW-1:0];
                    pc_d        = req_pc;
                    req_ready_d = 1'b0;
                    if (illegal || misalign) begin
                        state_d     = ST_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_exc_d   = 1'b1;
                        rsp_cause_d = fault_cause(req_we, !illegal);
                        rsp_data_d  = '0;
                        rsp_pc_d    = req_pc;
                    end else begin
                        state_d         = ST_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                        mem_req_we_d    = req_we;
                        mem_req_wdata_d = wdata_sh;
                        mem_req_wstrb_d = wstrb_sh;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d         = ST_RSP;
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                end
            end
            ST_RSP: begin
                cnt_d = cnt_inc;
                // A response arriving on the timeout cycle still completes normally.
                if (mem_rsp_valid) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_exc_d   = mem_rsp_err;
                    rsp_cause_d = mem_rsp_err ? fault_cause(mem_req_we_q, 1'b0) : 4'd0;
                    rsp_data_d  = (mem_rsp_err || mem_req_we_q) ? '0 : ldata;
                    rsp_pc_d    = pc_q;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_exc_d   = 1'b1;
                    rsp_cause_d = fault_cause(mem_req_we_q, 1'b0);
                    rsp_data_d  = '0;
                    rsp_pc_d    = pc_q;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            memop_q         <= '0;
            off_q           <= '0;
            pc_q            <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_we_q    <= 1'b0;
            mem_req_wdata_q <= '0;
            mem_req_wstrb_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_exc_q       <= 1'b0;
            rsp_cause_q     <= '0;
            rsp_pc_q        <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            memop_q         <= memop_d;
            off_q           <= off_d;
            pc_q            <= pc_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_we_q    <= mem_req_we_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_wstrb_q <= mem_req_wstrb_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_exc_q       <= rsp_exc_d;
            rsp_cause_q     <= rsp_cause_d;
            rsp_pc_q        <= rsp_pc_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign busy          = !req_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_we    = mem_req_we_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign mem_req_wstrb = mem_req_wstrb_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_exc       = rsp_exc_q;
    assign rsp_cause     = rsp_cause_q;
    assign rsp_pc        = rsp_pc_q;

endmodule

// File: tb/tb_lsu_hs.sv
// Bench for lsu_hs (XLEN=64, TIMEOUT_CYC=4): vector table plus hand-written
// back-pressure, timeout and reset sequences, completions checked from a queue.
module tb_lsu_hs;

    localparam int XLEN = 64;
    localparam int TMO  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_memop = 3'd0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [63:0] req_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = '0;
    logic        mem_rsp_err = 1'b0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_exc;
    logic [3:0]  rsp_cause;
    logic [63:0] rsp_pc;
    logic        busy;

    lsu_hs #(.XLEN(XLEN), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
        .rsp_cause(rsp_cause), .rsp_pc(rsp_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  memop;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        logic        bus;
        logic [63:0] exp_addr;
        logic [7:0]  exp_wstrb;
        logic [63:0] exp_wdata;
        logic [63:0] exp_data;
        logic        exp_exc;
        logic [3:0]  exp_cause;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        exc;
        logic [3:0]  cause;
        logic [63:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   n_rsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add_vec(input logic we, input logic [2:0] memop, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] rdata, input logic err,
                           input logic bus, input logic [63:0] exp_addr, input logic [7:0] exp_wstrb,
                           input logic [63:0] exp_wdata, input logic [63:0] exp_data,
                           input logic exp_exc, input logic [3:0] exp_cause);
        vec_t v;
        v.we = we; v.memop = memop; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.err = err; v.bus = bus; v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
        v.exp_wdata = exp_wdata; v.exp_data = exp_data; v.exp_exc = exp_exc; v.exp_cause = exp_cause;
        vecs.push_back(v);
    endtask

    task automatic push_exp(input logic [63:0] data, input logic exc, input logic [3:0] cause,
                            input logic [63:0] pc);
        exp_t e;
        e.data = data; e.exc = exc; e.cause = cause; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] memop, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [63:0] pc);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_memop = memop;
        req_addr = addr; req_wdata = wdata; req_pc = pc;
    endtask

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_data", rsp_data, mon_e.data);
                chk("rsp_exc", 64'(rsp_exc), 64'(mon_e.exc));
                chk("rsp_cause", 64'(rsp_cause), 64'(mon_e.cause));
                chk("rsp_pc", rsp_pc, mon_e.pc);
            end
        end
    end

    task automatic run_vec(input vec_t v, input logic [63:0] pc);
        drive_req(v.we, v.memop, v.addr, v.wdata, pc);
        push_exp(v.exp_data, v.exp_exc, v.exp_cause, pc);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.bus) begin
            chk("mreq_valid", 64'(mem_req_valid), 64'd1);
            chk("mreq_addr", mem_req_addr, v.exp_addr);
            chk("mreq_wstrb", 64'(mem_req_wstrb), 64'(v.exp_wstrb));
            chk("mreq_we", 64'(mem_req_we), 64'(v.we));
            if (v.we) chk("mreq_wdata", mem_req_wdata, v.exp_wdata);
            chk("busy", 64'(busy), 64'd1);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk("mreq_drop", 64'(mem_req_valid), 64'd0);
            mem_rsp_valid = 1'b1; mem_rsp_rdata = v.rdata; mem_rsp_err = v.err;
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
        end else begin
            chk("no_bus_req", 64'(mem_req_valid), 64'd0);
        end
        chk("rsp_latency", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        chk("ready_after", 64'(req_ready), 64'd1);
    endtask

    // Access that handshakes at once and answers after rsp_at cycles (never if out of range).
    task automatic run_slow(input logic [2:0] memop, input logic [63:0] addr, input logic [63:0] rdata,
                            input int rsp_at, input logic [63:0] pc);
        int c;
        drive_req(1'b0, memop, addr, 64'd0, pc);
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        c = 1;
        while (rsp_valid !== 1'b1 && c <= 20) begin
            if (c == rsp_at) begin
                mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
            end
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            c++;
        end
        chk("slow_latency", 64'(c), 64'(TMO + 1));
        @(negedge clk);
        chk("slow_idle", 64'(req_ready), 64'd1);
    endtask

    initial begin
        int rsp0;

        //       we    f3      addr        wdata                  rdata                  err  bus  maddr       strb   mwdata                 data                   exc  cause
        add_vec(1'b0, 3'b000, 64'h1003, 64'h0,                  64'h0000_0000_8000_0000, 1'b0, 1'b1, 64'h1000, 8'h08, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 4'd0);
        add_vec(1'b1, 3'b001, 64'h1006, 64'hABCD,               64'h0,                  1'b0, 1'b1, 64'h1000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0,                  1'b0, 4'd0);
        add_vec(1'b0, 3'b101, 64'h2002, 64'h0,                  64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 64'h2000, 8'h0C, 64'h0,                  64'h0000_0000_0000_9ABC, 1'b0, 4'd0);
        add_vec(1'b0, 3'b010, 64'h2004, 64'h0,                  64'h8765_4321_0000_0000, 1'b0, 1'b1, 64'h2000, 8'hF0, 64'h0,                  64'hFFFF_FFFF_8765_4321, 1'b0, 4'd0);
        add_vec(1'b0, 3'b110, 64'h2004, 64'h0,                  64'h8765_4321_0000_0000, 1'b0, 1'b1, 64'h2000, 8'hF0, 64'h0,                  64'h0000_0000_8765_4321, 1'b0, 4'd0);
        add_vec(1'b0, 3'b011, 64'h3000, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 64'h3000, 8'hFF, 64'h0,                  64'hDEAD_BEEF_CAFE_F00D, 1'b0, 4'd0);
        add_vec(1'b0, 3'b100, 64'h3007, 64'h0,                  64'hF100_0000_0000_0000, 1'b0, 1'b1, 64'h3000, 8'h80, 64'h0,                  64'h0000_0000_0000_00F1, 1'b0, 4'd0);
        add_vec(1'b0, 3'b001, 64'h3000, 64'h0,                  64'h0000_0000_0000_8001, 1'b0, 1'b1, 64'h3000, 8'h03, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 1'b0, 4'd0);
        add_vec(1'b1, 3'b000, 64'h4005, 64'h55,                 64'h0,                  1'b0, 1'b1, 64'h4000, 8'h20, 64'h0000_5500_0000_0000, 64'h0,                  1'b0, 4'd0);
        add_vec(1'b1, 3'b010, 64'h4004, 64'h1122_3344,          64'h0,                  1'b0, 1'b1, 64'h4000, 8'hF0, 64'h1122_3344_0000_0000, 64'h0,                  1'b0, 4'd0);
        add_vec(1'b1, 3'b011, 64'h4000, 64'h0102_0304_0506_0708, 64'h0,                 1'b0, 1'b1, 64'h4000, 8'hFF, 64'h0102_0304_0506_0708, 64'h0,                  1'b0, 4'd0);
        add_vec(1'b0, 3'b010, 64'h5000, 64'h0,                  64'h1111_2222_3333_4444, 1'b1, 1'b1, 64'h5000, 8'h0F, 64'h0,                  64'h0,                  1'b1, 4'd5);
        add_vec(1'b1, 3'b010, 64'h5008, 64'hDEAD_BEEF,          64'h0,                  1'b1, 1'b1, 64'h5008, 8'h0F, 64'hDEAD_BEEF,          64'h0,                  1'b1, 4'd7);
        add_vec(1'b0, 3'b111, 64'h5010, 64'h0,                  64'h0,                  1'b0, 1'b0, 64'h0,    8'h00, 64'h0,                  64'h0,                  1'b1, 4'd5);
        add_vec(1'b1, 3'b111, 64'h5018, 64'h0,                  64'h0,                  1'b0, 1'b0, 64'h0,    8'h00, 64'h0,                  64'h0,                  1'b1, 4'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        add_vec(1'b0, 3'b010, 64'h1002, 64'h0,                  64'h0,                  1'b0, 1'b0, 64'h0,    8'h00, 64'h0,                  64'h0,                  1'b1, 4'd4);
        add_vec(1'b1, 3'b010, 64'h1006, 64'h1122_3344,          64'h0,                  1'b0, 1'b0, 64'h0,    8'h00, 64'h0,                  64'h0,                  1'b1, 4'd6);
        add_vec(1'b0, 3'b001, 64'h1007, 64'h0,                  64'h0,                  1'b0, 1'b0, 64'h0,    8'h00, 64'h0,                  64'h0,                  1'b1, 4'd4);
`else
        add_vec(1'b0, 3'b010, 64'h1002, 64'h0,                  64'h0000_0000_CAFE_BABE, 1'b0, 1'b1, 64'h1000, 8'h3C, 64'h0,                  64'h0000_0000_0000_CAFE, 1'b0, 4'd0);
        add_vec(1'b1, 3'b010, 64'h1006, 64'h1122_3344,          64'h0,                  1'b0, 1'b1, 64'h1000, 8'hC0, 64'h3344_0000_0000_0000, 64'h0,                  1'b0, 4'd0);
        add_vec(1'b0, 3'b001, 64'h1007, 64'h0,                  64'hFF00_0000_0000_0000, 1'b0, 1'b1, 64'h1000, 8'h80, 64'h0,                  64'h0000_0000_0000_00FF, 1'b0, 4'd0);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mreq_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mreq_addr", mem_req_addr, 64'd0);
        chk("rst_mreq_we", 64'(mem_req_we), 64'd0);
        chk("rst_mreq_wdata", mem_req_wdata, 64'd0);
        chk("rst_mreq_wstrb", 64'(mem_req_wstrb), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_exc", 64'(rsp_exc), 64'd0);
        chk("rst_rsp_cause", 64'(rsp_cause), 64'd0);
        chk("rst_rsp_pc", rsp_pc, 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 64'h8000_0000 + 64'(i * 4));
        end

        // Back-pressure: 5 REQ wait cycles with a stray req_valid, response 2 cycles later.
        rsp0 = n_rsp;
        drive_req(1'b0, 3'b010, 64'h6008, 64'h0, 64'h9000_0000);
        push_exp(64'h0000_0000_7654_3210, 1'b0, 4'd0, 64'h9000_0000);
        @(negedge clk);
        req_addr = 64'h9999; req_memop = 3'b011; req_pc = 64'h1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(mem_req_valid), 64'd1);
            chk("bp_addr", mem_req_addr, 64'h6008);
            chk("bp_wstrb", 64'(mem_req_wstrb), 64'h0F);
            chk("bp_we", 64'(mem_req_we), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        chk("bp_valid_hs", 64'(mem_req_valid), 64'd1);
        @(negedge clk);
        mem_req_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_drop", 64'(mem_req_valid), 64'd0);
        for (int i = 0; i < 2; i++) begin
            chk("bp_wait_rsp", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hAAAA_BBBB_7654_3210;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("bp_rsp", 64'(rsp_valid), 64'd1);
        repeat (3) @(negedge clk);
        chk("bp_rsp_once", 64'(n_rsp - rsp0), 64'd1);
        chk("bp_mreq_idle", 64'(mem_req_valid), 64'd0);

        // Timeout with no response, then a response on the very last RSP cycle.
        push_exp(64'h0, 1'b1, 4'd5, 64'hA000_0000);
        run_slow(3'b011, 64'h7000, 64'h0, -1, 64'hA000_0000);
        push_exp(64'h0000_0000_0000_00AB, 1'b0, 4'd0, 64'hA000_0004);
        run_slow(3'b100, 64'h7001, 64'h0000_0000_0000_AB00, TMO, 64'hA000_0004);

        // Reset while waiting in RSP, then a stray response.
        rsp0 = n_rsp;
        drive_req(1'b0, 3'b010, 64'h6010, 64'h0, 64'hB000_0000);
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rrst_ready", 64'(req_ready), 64'd1);
        chk("rrst_busy", 64'(busy), 64'd0);
        chk("rrst_mreq", 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h1234;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rrst_no_rsp", 64'(rsp_valid), 64'd0);
        repeat (2) @(negedge clk);
        chk("rrst_no_rsp_cnt", 64'(n_rsp - rsp0), 64'd0);
        chk("rrst_ready2", 64'(req_ready), 64'd1);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
